pwm_ramp_ctrl: RTL and testbench

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

---
 rtl/pwm_ramp_ctrl.sv | 142 ++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// PWM compare-end ramp sequencer sharing the PWM register bus with a host port that always has priority.
// Optional feature: define PWM_RAMP_HOST_OVERRIDE_EN so that a host write to the ramping channel aborts the ramp.
module pwm_ramp_ctrl #(
    parameter int          WIDTH        = 16,
    parameter logic [7:0]  CMP_END_BASE = 8'h10,
    parameter logic [7:0]  CMP_STRIDE   = 8'h04
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [7:0]       host_addr_i,
    input  logic [WIDTH-1:0] host_wdata_i,
    input  logic             host_wr_en_i,
    input  logic             host_rd_en_i,
    output logic [WIDTH-1:0] host_rdata_o,
    output logic [7:0]       bus_addr_o,
    output logic [WIDTH-1:0] bus_wdata_o,
    output logic             bus_wr_en_o,
    output logic             bus_rd_en_o,
    input  logic [WIDTH-1:0] bus_rdata_i,
    input  logic             ramp_start_i,
    input  logic [2:0]       ramp_ch_i,
    input  logic [WIDTH-1:0] ramp_init_i,
    input  logic [WIDTH-1:0] ramp_target_i,
    input  logic [WIDTH-1:0] ramp_step_i,
    input  logic [WIDTH-1:0] ramp_interval_i,
    input  logic             ramp_abort_i,
    output logic             ramp_busy_o,
    output logic             ramp_done_o,
    output logic             ramp_aborted_o,
    output logic [WIDTH-1:0] ramp_cur_o
);

    typedef enum logic [2:0] {IDLE, WRITE, WAIT, CALC, DONE} state_t;

    state_t           state;
    logic [2:0]       ch;
    logic [WIDTH-1:0] cur, target, step, interval, cnt;
    logic             up;

    logic             host_act, override_hit, abort_req, wr_fire;
    logic [7:0]       ramp_addr;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] cur_nxt;

    assign host_act  = host_wr_en_i | host_rd_en_i;
    assign ramp_addr = 8'(CMP_END_BASE + {5'd0, ch} * CMP_STRIDE);

`ifdef PWM_RAMP_HOST_OVERRIDE_EN
    assign override_hit = host_wr_en_i && (host_addr_i == ramp_addr) && (state != IDLE);
`else
    assign override_hit = 1'b0;
`endif

    assign abort_req = (ramp_abort_i | override_hit) && (state != IDLE);
    // Ramp write is dropped in the abort cycle so nothing escapes after an abort request.
    assign wr_fire   = (state == WRITE) && !host_act && !abort_req;

    assign host_rdata_o = bus_rdata_i;
    assign bus_wr_en_o  = host_act ? host_wr_en_i : wr_fire;
    assign bus_rd_en_o  = host_act ? host_rd_en_i : 1'b0;
    assign bus_addr_o   = host_act ? host_addr_i  : (wr_fire ? ramp_addr : 8'd0);
    assign bus_wdata_o  = host_act ? host_wdata_i : (wr_fire ? cur : '0);

    // Saturating step computed one bit wide so neither direction can wrap.
    always_comb begin
        sum     = {1'b0, cur} + {1'b0, step};
        diff    = {1'b0, cur} - {1'b0, step};
        cur_nxt = target;
        if (step != '0) begin
            if (up)
                cur_nxt = (sum > {1'b0, target}) ? target : sum[WIDTH-1:0];
            else
                cur_nxt = (diff[WIDTH] || diff[WIDTH-1:0] < target) ? target : diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            ch             <= '0;
            cur            <= '0;
            target         <= '0;
            step           <= '0;
            interval       <= '0;
            cnt            <= '0;
            up             <= 1'b0;
            ramp_busy_o    <= 1'b0;
            ramp_done_o    <= 1'b0;
            ramp_aborted_o <= 1'b0;
            ramp_cur_o     <= '0;
        end else begin
            ramp_done_o    <= 1'b0;
            ramp_aborted_o <= 1'b0;
            if (wr_fire)
                ramp_cur_o <= cur;
            if (abort_req) begin
                state          <= IDLE;
                ramp_busy_o    <= 1'b0;
                ramp_aborted_o <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (ramp_start_i) begin
                        ch          <= ramp_ch_i;
                        cur         <= ramp_init_i;
                        target      <= ramp_target_i;
                        step        <= ramp_step_i;
                        interval    <= ramp_interval_i;
                        up          <= ramp_target_i >= ramp_init_i;
                        ramp_busy_o <= 1'b1;
                        state       <= WRITE;
                    end
                    WRITE: if (wr_fire) begin
                        if (cur == target) begin
                            state       <= DONE;
                            ramp_done_o <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= (interval == '0) ? WIDTH'(1) : interval;
                        end
                    end
                    WAIT: begin
                        if (cnt == WIDTH'(1)) state <= CALC;
                        else                  cnt   <= cnt - WIDTH'(1);
                    end
                    CALC: begin
                        cur   <= cur_nxt;
                        state <= WRITE;
                    end
                    DONE: begin
                        ramp_busy_o <= 1'b0;
                        state       <= IDLE;
                    end
                    default: begin
                        ramp_busy_o <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: expected bus writes are queued by the stimulus, a negedge monitor pops and compares.
module tb_pwm_ramp_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   host_addr = '0;
    logic [W-1:0] host_wdata = '0;
    logic         host_wr_en = 1'b0, host_rd_en = 1'b0;
    logic [W-1:0] host_rdata;
    logic [7:0]   bus_addr;
    logic [W-1:0] bus_wdata, bus_rdata = '0;
    logic         bus_wr_en, bus_rd_en;
    logic         ramp_start = 1'b0, ramp_abort = 1'b0;
    logic [2:0]   ramp_ch = '0;
    logic [W-1:0] ramp_init = '0, ramp_target = '0, ramp_step = '0, ramp_interval = '0;
    logic         ramp_busy, ramp_done, ramp_aborted;
    logic [W-1:0] ramp_cur;

    pwm_ramp_ctrl #(.WIDTH(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .host_addr_i(host_addr), .host_wdata_i(host_wdata),
        .host_wr_en_i(host_wr_en), .host_rd_en_i(host_rd_en), .host_rdata_o(host_rdata),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_wr_en_o(bus_wr_en),
        .bus_rd_en_o(bus_rd_en), .bus_rdata_i(bus_rdata),
        .ramp_start_i(ramp_start), .ramp_ch_i(ramp_ch), .ramp_init_i(ramp_init),
        .ramp_target_i(ramp_target), .ramp_step_i(ramp_step), .ramp_interval_i(ramp_interval),
        .ramp_abort_i(ramp_abort), .ramp_busy_o(ramp_busy), .ramp_done_o(ramp_done),
        .ramp_aborted_o(ramp_aborted), .ramp_cur_o(ramp_cur)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   addr;
        logic [W-1:0] data;
        int           gap;   // cycles since previous bus write; 0 = unchecked
    } exp_t;

    exp_t exp_q[$];
    int   total = 0, bad = 0;
    int   cyc = 0, last_wr = 0;
    int   done_cnt = 0, abort_cnt = 0;

    function automatic void chk(string name, longint act, longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (ramp_done)    done_cnt++;
            if (ramp_aborted) abort_cnt++;
            if (bus_wr_en) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: addr=%h data=%0d, none expected", bus_addr, bus_wdata);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", bus_addr, e.addr);
                    chk("wr_data", bus_wdata, e.data);
                    if (e.gap > 0) chk("wr_gap", cyc - last_wr, e.gap);
                end
                last_wr = cyc;
            end
        end
    end

    task automatic push(input logic [7:0] a, input logic [W-1:0] d, input int g);
        exp_t e;
        e.addr = a; e.data = d; e.gap = g;
        exp_q.push_back(e);
    endtask

    task automatic start_ramp(input logic [2:0] c, input int ini, input int tgt, input int stp, input int iv);
        @(posedge clk); #1;
        ramp_ch = c; ramp_init = W'(ini); ramp_target = W'(tgt);
        ramp_step = W'(stp); ramp_interval = W'(iv); ramp_start = 1'b1;
        @(posedge clk); #1;
        ramp_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while (ramp_busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_busy_timeout"}, ramp_busy, 0);
        @(negedge clk);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int d0, a0;
        repeat (3) @(negedge clk);
        chk("rst_busy", ramp_busy, 0);
        chk("rst_done", ramp_done, 0);
        chk("rst_aborted", ramp_aborted, 0);
        chk("rst_cur", ramp_cur, 0);
        chk("rst_bus_wr", bus_wr_en, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // host read passthrough and idle bus
        @(posedge clk); #1;
        host_rd_en = 1'b1; host_addr = 8'h20; bus_rdata = 16'h1234;
        @(negedge clk);
        chk("rd_en_pass", bus_rd_en, 1);
        chk("rd_addr_pass", bus_addr, 8'h20);
        chk("rd_data_pass", host_rdata, 16'h1234);
        chk("rd_no_write", bus_wr_en, 0);
        @(posedge clk); #1 host_rd_en = 1'b0; host_addr = '0;
        @(negedge clk);
        chk("idle_no_rd", bus_rd_en, 0);
        chk("idle_addr", bus_addr, 0);

        // up-ramp on channel 2: 0,30,60,90,100 at 0x18, 6 cycles between write cycles
        d0 = done_cnt;
        push(8'h18, 0, 0); push(8'h18, 30, 6); push(8'h18, 60, 6); push(8'h18, 90, 6); push(8'h18, 100, 6);
        start_ramp(3'd2, 0, 100, 30, 4);
        @(negedge clk);
        chk("up_busy", ramp_busy, 1);
        wait_idle("up", 200);
        chk("up_done_once", done_cnt - d0, 1);
        chk("up_cur", ramp_cur, 100);

        // down-ramp, no underflow; a second start while busy is ignored
        d0 = done_cnt;
        push(8'h10, 500, 0); push(8'h10, 300, 3); push(8'h10, 100, 3);
        start_ramp(3'd0, 500, 100, 200, 1);
        @(posedge clk); #1 ramp_start = 1'b1; ramp_ch = 3'd5; ramp_init = 16'd9;
        @(posedge clk); #1 ramp_start = 1'b0;
        wait_idle("down", 200);
        chk("down_done_once", done_cnt - d0, 1);
        chk("down_cur", ramp_cur, 100);

        // init == target on channel 7: single write
        d0 = done_cnt;
        push(8'h2C, 7, 0);
        start_ramp(3'd7, 7, 7, 3, 2);
        wait_idle("eq", 50);
        chk("eq_done_once", done_cnt - d0, 1);

        // step 0 jumps straight to target, interval 0 waits one cycle
        push(8'h14, 10, 0); push(8'h14, 50, 3);
        start_ramp(3'd1, 10, 50, 0, 0);
        wait_idle("step0", 50);

        // host holds the bus three cycles while the FSM sits in WRITE
        push(8'h40, 16'hA1, 0); push(8'h41, 16'hA2, 1); push(8'h42, 16'hA3, 1); push(8'h14, 5, 1);
        start_ramp(3'd1, 5, 5, 1, 1);
        for (int k = 0; k < 3; k++) begin
            host_wr_en = 1'b1; host_addr = 8'(8'h40 + k); host_wdata = W'(16'hA1 + k);
            @(posedge clk); #1;
        end
        host_wr_en = 1'b0; host_addr = '0; host_wdata = '0;
        wait_idle("hold", 50);

        // abort during WAIT
        d0 = done_cnt; a0 = abort_cnt;
        push(8'h18, 0, 0);
        start_ramp(3'd2, 0, 100, 30, 4);
        @(posedge clk); #1;
        @(posedge clk); #1 ramp_abort = 1'b1;
        @(posedge clk); #1 ramp_abort = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort_pulse", abort_cnt - a0, 1);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_busy", ramp_busy, 0);
        chk("abort_queue_empty", exp_q.size(), 0);

        // host write to the ramping channel's compare-end during WAIT
        d0 = done_cnt; a0 = abort_cnt;
        push(8'h18, 0, 0); push(8'h18, 16'h0BEE, 2);
`ifndef PWM_RAMP_HOST_OVERRIDE_EN
        push(8'h18, 30, 4); push(8'h18, 60, 6); push(8'h18, 90, 6); push(8'h18, 100, 6);
`endif
        start_ramp(3'd2, 0, 100, 30, 4);
        @(posedge clk); #1;
        @(posedge clk); #1 host_wr_en = 1'b1; host_addr = 8'h18; host_wdata = 16'h0BEE;
        @(posedge clk); #1 host_wr_en = 1'b0; host_addr = '0; host_wdata = '0;
        wait_idle("ovr", 200);
`ifdef PWM_RAMP_HOST_OVERRIDE_EN
        chk("ovr_aborted", abort_cnt - a0, 1);
        chk("ovr_no_done", done_cnt - d0, 0);
        chk("ovr_cur", ramp_cur, 0);
`else
        chk("ovr_no_abort", abort_cnt - a0, 0);
        chk("ovr_done", done_cnt - d0, 1);
        chk("ovr_cur", ramp_cur, 100);
`endif

        // reset mid-ramp: no write, done or aborted afterwards
        d0 = done_cnt; a0 = abort_cnt;
        push(8'h18, 0, 0);
        start_ramp(3'd2, 0, 100, 30, 4);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", ramp_busy, 0);
        chk("midrst_bus_wr", bus_wr_en, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_abort", abort_cnt - a0, 0);
        chk("midrst_cur", ramp_cur, 0);
        chk("midrst_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
